// File: rtl/car_draw_scheduler.sv
// car_draw_scheduler: grants car sprite engines one at a time, muxes the active car's
// pixel bus onto the VGA port, and checks each car box against the player box.
module car_draw_scheduler #(
    parameter int NUM_CARS       = 8,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int CAR_W          = 8,
    parameter int CAR_H          = 4,
    parameter int PLAYER_W       = 4,
    parameter int PLAYER_H       = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  clear_collision,
    input  logic [NUM_CARS-1:0]   car_finish,
    input  logic [NUM_CARS-1:0]   car_plot,
    input  logic [8*NUM_CARS-1:0] car_x,
    input  logic [7*NUM_CARS-1:0] car_y,
    input  logic [3*NUM_CARS-1:0] car_colour,
    input  logic [8*NUM_CARS-1:0] car_x_ori,
    input  logic [7*NUM_CARS-1:0] car_y_ori,
    input  logic [7:0]            player_x,
    input  logic [6:0]            player_y,
    output logic [NUM_CARS-1:0]   car_en,
    output logic                  vga_plot,
    output logic [7:0]            vga_x,
    output logic [6:0]            vga_y,
    output logic [2:0]            vga_colour,
    output logic                  busy,
    output logic                  round_done,
    output logic                  collision,
    output logic [2:0]            collision_id,
    output logic                  timeout_err
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [2:0] {IDLE, GRANT, WAIT_FIN, CHECK, DONE} state_t;
    state_t state, state_n;
    logic [2:0] sel, sel_n;
    logic [CW-1:0] cnt, cnt_n;
    logic tmo_set, overlap, wf;
    logic       fin_a [8];
    logic       plot_a [8];
    logic [7:0] x_a [8];
    logic [6:0] y_a [8];
    logic [2:0] col_a [8];
    logic [7:0] xo_a [8];
    logic [6:0] yo_a [8];
    // Pad per-car buses to 8 entries so a 3-bit sel indexes safely for any NUM_CARS
    for (genvar i = 0; i < 8; i++) begin : g_car
        if (i < NUM_CARS) begin : g_on
            assign fin_a[i]  = car_finish[i];
            assign plot_a[i] = car_plot[i];
            assign x_a[i]    = car_x[8*i +: 8];
            assign y_a[i]    = car_y[7*i +: 7];
            assign col_a[i]  = car_colour[3*i +: 3];
            assign xo_a[i]   = car_x_ori[8*i +: 8];
            assign yo_a[i]   = car_y_ori[7*i +: 7];
        end else begin : g_off
            assign fin_a[i]  = 1'b0;
            assign plot_a[i] = 1'b0;
            assign x_a[i]    = '0;
            assign y_a[i]    = '0;
            assign col_a[i]  = '0;
            assign xo_a[i]   = '0;
            assign yo_a[i]   = '0;
        end
    end
    always_comb begin
        state_n = state;
        sel_n   = sel;
        cnt_n   = cnt;
        tmo_set = 1'b0;
        case (state)
            IDLE: if (start) begin
                state_n = GRANT;
                sel_n   = 3'd0;
            end
            GRANT: begin
                state_n = WAIT_FIN;
                cnt_n   = '0;
            end
            WAIT_FIN: begin
                cnt_n = cnt + 1'b1;
                if (fin_a[sel]) state_n = CHECK;
                else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_n = CHECK;
                    tmo_set = 1'b1;
                end
            end
            CHECK: begin
                state_n = (sel == 3'(NUM_CARS - 1)) ? DONE : GRANT;
                sel_n   = (sel == 3'(NUM_CARS - 1)) ? sel : sel + 3'd1;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    // Widened sums so boxes near the right/bottom screen edge never wrap
    assign overlap = state == CHECK
        && {1'b0, player_x} < {1'b0, xo_a[sel]} + 9'(CAR_W)
        && {1'b0, xo_a[sel]} < {1'b0, player_x} + 9'(PLAYER_W)
        && {1'b0, player_y} < {1'b0, yo_a[sel]} + 8'(CAR_H)
        && {1'b0, yo_a[sel]} < {1'b0, player_y} + 8'(PLAYER_H);
    assign wf         = state == WAIT_FIN;
    assign car_en     = state == GRANT ? NUM_CARS'(1) << sel : '0;
    assign vga_plot   = wf & plot_a[sel];
    assign vga_x      = wf ? x_a[sel] : '0;
    assign vga_y      = wf ? y_a[sel] : '0;
    assign vga_colour = wf ? col_a[sel] : '0;
    assign busy       = state != IDLE;
    assign round_done = state == DONE;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            sel          <= 3'd0;
            cnt          <= '0;
            collision    <= 1'b0;
            collision_id <= 3'd0;
            timeout_err  <= 1'b0;
        end else begin
            state        <= state_n;
            sel          <= sel_n;
            cnt          <= cnt_n;
            timeout_err  <= timeout_err | tmo_set;
            collision    <= overlap | (collision & ~clear_collision);
            collision_id <= overlap && (!collision || clear_collision) ? sel
                          : clear_collision ? 3'd0 : collision_id;
        end
    end
endmodule

// File: tb/tb_car_draw_scheduler.sv
// tb_car_draw_scheduler: randomized rounds checked cycle by cycle against a schedule
// computed from per-car finish delays, plus directed collision/timeout/reset scenarios.
module tb_car_draw_scheduler;
    localparam int NC = 8;
    localparam int T  = 16;
    logic clk = 0, resetn = 0, start = 0, clear_collision = 0;
    logic [NC-1:0] car_finish = '0, car_plot = '0;
    logic [8*NC-1:0] car_x = '0, car_x_ori = '0;
    logic [7*NC-1:0] car_y = '0, car_y_ori = '0;
    logic [3*NC-1:0] car_colour = '0;
    logic [7:0] player_x = '0;
    logic [6:0] player_y = '0;
    logic [NC-1:0] car_en;
    logic vga_plot, busy, round_done, collision, timeout_err;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour, collision_id;
    int checks = 0, errors = 0;
    int d[NC], ox[NC], oy[NC];
    int px, py, m_id;
    bit m_coll, m_tmo;
    bit rnd_pix = 1;
    int clr_rate = 0;
    int force_clr_car = -1;

    car_draw_scheduler #(.NUM_CARS(NC), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .resetn(resetn), .start(start), .clear_collision(clear_collision),
        .car_finish(car_finish), .car_plot(car_plot), .car_x(car_x), .car_y(car_y),
        .car_colour(car_colour), .car_x_ori(car_x_ori), .car_y_ori(car_y_ori),
        .player_x(player_x), .player_y(player_y), .car_en(car_en), .vga_plot(vga_plot),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .busy(busy),
        .round_done(round_done), .collision(collision), .collision_id(collision_id),
        .timeout_err(timeout_err));

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic bit overlaps(input int k);
        return px < ox[k] + 8 && ox[k] < px + 4 && py < oy[k] + 4 && oy[k] < py + 4;
    endfunction

    // Cycle 0 raises start; car k is granted at g[k], waits w[k] cycles, checks at g[k]+w[k]+1.
    task automatic run_round(input int abort_car);
        int g[NC], w[NC];
        int dn, cur, chk, abort_at;
        bit clr;
        logic [NC-1:0] ex_en;
        logic ex_plot;
        logic [7:0] ex_x;
        logic [6:0] ex_y;
        logic [2:0] ex_c;
        for (int i = 0; i < NC; i++) begin
            w[i] = (d[i] >= 1 && d[i] <= T) ? d[i] : T;
            g[i] = (i == 0) ? 1 : g[i-1] + w[i-1] + 2;
            car_x_ori[8*i +: 8] = 8'(ox[i]);
            car_y_ori[7*i +: 7] = 7'(oy[i]);
        end
        dn = g[NC-1] + w[NC-1] + 2;
        abort_at = (abort_car >= 0) ? g[abort_car] + 2 : -1;
        player_x = 8'(px);
        player_y = 7'(py);
        for (int c = 0; c <= dn + 1; c++) begin
            @(posedge clk);
            #1;
            start = (c == 0) ? 1'b1 : (c <= dn && $urandom_range(0, 3) == 0);
            cur = -1;
            chk = -1;
            for (int i = 0; i < NC; i++) begin
                if (c > g[i] && c <= g[i] + w[i]) cur = i;
                if (c == g[i] + w[i] + 1) chk = i;
            end
            for (int i = 0; i < NC; i++) begin
                car_finish[i] = (cur == i) ? (d[i] >= 1 && d[i] <= T && c == g[i] + d[i])
                                           : ($urandom_range(0, 5) == 0);
                car_plot[i] = rnd_pix ? 1'($urandom) : (i < 2);
                car_x[8*i +: 8] = rnd_pix ? 8'($urandom) : (i == 1 ? 8'd40 : i == 0 ? 8'd1 : 8'd0);
                car_y[7*i +: 7] = rnd_pix ? 7'($urandom) : (i == 1 ? 7'd90 : i == 0 ? 7'd1 : 7'd0);
                car_colour[3*i +: 3] = rnd_pix ? 3'($urandom) : (i == 1 ? 3'b101 : i == 0 ? 3'b111 : 3'b000);
            end
            clr = (force_clr_car >= 0 && chk == force_clr_car) || ($urandom_range(0, 99) < clr_rate);
            clear_collision = clr;
            if (c == abort_at) begin
                #2 resetn = 0;
                #1;
                checks++;
                if ({car_en, vga_plot, vga_x, vga_y, vga_colour, busy, round_done,
                     collision, collision_id, timeout_err} !== '0) begin
                    errors++;
                    $display("FAIL reset_abort got %h expected 0", {car_en, vga_plot, vga_x, vga_y,
                             vga_colour, busy, round_done, collision, collision_id, timeout_err});
                end
                m_coll = 0;
                m_id = 0;
                m_tmo = 0;
                @(posedge clk);
                #1;
                resetn = 1;
                start = 0;
                car_finish = '0;
                clear_collision = 0;
                return;
            end
            ex_en = '0;
            for (int i = 0; i < NC; i++) if (c == g[i]) ex_en[i] = 1'b1;
            ex_plot = cur >= 0 ? car_plot[cur] : 1'b0;
            ex_x = cur >= 0 ? car_x[8*cur +: 8] : 8'd0;
            ex_y = cur >= 0 ? car_y[7*cur +: 7] : 7'd0;
            ex_c = cur >= 0 ? car_colour[3*cur +: 3] : 3'd0;
            #3;
            checks++;
            if (car_en !== ex_en) begin
                errors++;
                $display("FAIL car_en cycle %0d got %b expected %b", c, car_en, ex_en);
            end
            checks++;
            if (busy !== (c >= 1 && c <= dn) || round_done !== (c == dn)) begin
                errors++;
                $display("FAIL busy_done cycle %0d got %b%b expected %b%b", c, busy, round_done,
                         c >= 1 && c <= dn, c == dn);
            end
            checks++;
            if ({vga_plot, vga_x, vga_y, vga_colour} !== {ex_plot, ex_x, ex_y, ex_c}) begin
                errors++;
                $display("FAIL vga_mux cycle %0d got %b/%0d/%0d/%b expected %b/%0d/%0d/%b", c,
                         vga_plot, vga_x, vga_y, vga_colour, ex_plot, ex_x, ex_y, ex_c);
            end
            checks++;
            if (collision !== m_coll || collision_id !== 3'(m_id) || timeout_err !== m_tmo) begin
                errors++;
                $display("FAIL sticky cycle %0d got coll=%b id=%0d tmo=%b expected coll=%b id=%0d tmo=%b",
                         c, collision, collision_id, timeout_err, m_coll, m_id, m_tmo);
            end
            for (int i = 0; i < NC; i++)
                if (c == g[i] + w[i] && !(d[i] >= 1 && d[i] <= T)) m_tmo = 1;
            if (clr) begin
                m_coll = 0;
                m_id = 0;
            end
            if (chk >= 0 && overlaps(chk) && !m_coll) begin
                m_coll = 1;
                m_id = chk;
            end
        end
    endtask

    task automatic far_cars();
        for (int i = 0; i < NC; i++) begin
            d[i] = $urandom_range(1, 8);
            ox[i] = 200;
            oy[i] = 10;
        end
        px = 30;
        py = 90;
    endtask

    task automatic do_clear();
        @(posedge clk);
        #1 clear_collision = 1;
        @(posedge clk);
        #1 clear_collision = 0;
        m_coll = 0;
        m_id = 0;
        #3;
        checks++;
        if (collision !== 1'b0 || collision_id !== 3'd0) begin
            errors++;
            $display("FAIL clear got coll=%b id=%0d expected 0/0", collision, collision_id);
        end
    endtask

    task automatic test_reset();
        resetn = 0;
        repeat (3) begin
            @(posedge clk);
            #1 start = 1;
            car_finish = '1;
            car_plot = '1;
            #3;
            checks++;
            if ({car_en, vga_plot, vga_x, vga_y, vga_colour, busy, round_done,
                 collision, collision_id, timeout_err} !== '0) begin
                errors++;
                $display("FAIL reset_hold got %b%b%b expected 000", busy, car_en != 0, timeout_err);
            end
        end
        start = 0;
        car_finish = '0;
        car_plot = '0;
        resetn = 1;
        m_coll = 0;
        m_id = 0;
        m_tmo = 0;
        far_cars();
        for (int i = 0; i < NC; i++) d[i] = 5;
        d[1] = 0;
        ox[0] = 26;
        oy[0] = 90;
        run_round(3);
    endtask

    task automatic test_handshake();
        far_cars();
        for (int i = 0; i < NC; i++) d[i] = 5;
        run_round(-1);
    endtask

    task automatic test_pixel_mux();
        rnd_pix = 0;
        far_cars();
        run_round(-1);
        rnd_pix = 1;
    endtask

    task automatic test_timeout();
        far_cars();
        d[0] = T;
        run_round(-1);
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_boundary got %b expected 0", timeout_err);
        end
        far_cars();
        d[1] = 0;
        d[3] = T + 1;
        run_round(-1);
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_set got %b expected 1", timeout_err);
        end
    endtask

    task automatic test_collision();
        do_clear();
        far_cars();
        ox[2] = 26;
        oy[2] = 90;
        ox[4] = 31;
        oy[4] = 91;
        run_round(-1);
        checks++;
        if (collision !== 1'b1 || collision_id !== 3'd2) begin
            errors++;
            $display("FAIL first_id got coll=%b id=%0d expected 1/2", collision, collision_id);
        end
        do_clear();
        far_cars();
        for (int i = 0; i < NC; i++) ox[i] = 0;
        px = 253;
        ox[6] = 254;
        oy[6] = 90;
        run_round(-1);
        checks++;
        if (collision !== 1'b1 || collision_id !== 3'd6) begin
            errors++;
            $display("FAIL edge_nowrap got coll=%b id=%0d expected 1/6", collision, collision_id);
        end
    endtask

    task automatic test_touch_and_clear();
        do_clear();
        far_cars();
        px = 34;
        ox[0] = 26;
        oy[0] = 90;
        ox[3] = 34;
        oy[3] = 94;
        run_round(-1);
        checks++;
        if (collision !== 1'b0) begin
            errors++;
            $display("FAIL touch got coll=%b expected 0", collision);
        end
        ox[1] = 30;
        ox[5] = 32;
        oy[1] = 90;
        oy[5] = 90;
        force_clr_car = 5;
        run_round(-1);
        force_clr_car = -1;
        checks++;
        if (collision !== 1'b1 || collision_id !== 3'd5) begin
            errors++;
            $display("FAIL clear_same_cycle got coll=%b id=%0d expected 1/5", collision, collision_id);
        end
    endtask

    task automatic test_random();
        clr_rate = 10;
        repeat (6) begin
            px = $urandom_range(10, 240);
            py = $urandom_range(5, 120);
            for (int i = 0; i < NC; i++) begin
                d[i] = $urandom_range(0, T + 2);
                ox[i] = px + $urandom_range(0, 20) - 10;
                oy[i] = py + $urandom_range(0, 10) - 5;
            end
            run_round(-1);
        end
        clr_rate = 0;
    endtask

    initial begin
        test_reset();
        test_handshake();
        test_pixel_mux();
        test_timeout();
        test_collision();
        test_touch_and_clear();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
